// File: rtl/fdct4_serial_pkg.sv
// fdct_pkg: shared definitions for the 4-point forward DCT.
//   DW_DEF        default signed sample/coefficient width
//   C64/C83/C36   HEVC 4-point transform coefficients
//   state_t       serial wrapper FSM states
package fdct_pkg;

    localparam int DW_DEF = 25;

    localparam int C64 = 64;
    localparam int C83 = 83;
    localparam int C36 = 36;

    typedef enum logic [1:0] {
        COLLECT,
        CALC,
        EMIT
    } state_t;

endpackage

// File: rtl/fdct4_serial_butterfly.sv
// fdct4_butterfly: combinational 4-point forward DCT (partial butterfly).
//   x0..x3  in   signed samples, DW bits
//   y0..y3  out  signed coefficients, rounded with ADD, arithmetic shift by SHIFT,
//                truncated to DW bits (no saturation)
// Internal arithmetic is DW+10 bits so no intermediate sum can overflow.
module fdct4_butterfly
    import fdct_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int SHIFT = 1,
    parameter int ADD   = 1 << (SHIFT - 1)
) (
    input  logic signed [DW-1:0] x0,
    input  logic signed [DW-1:0] x1,
    input  logic signed [DW-1:0] x2,
    input  logic signed [DW-1:0] x3,
    output logic signed [DW-1:0] y0,
    output logic signed [DW-1:0] y1,
    output logic signed [DW-1:0] y2,
    output logic signed [DW-1:0] y3
);

    localparam int IW = DW + 10;

    localparam logic signed [IW-1:0] K64  = IW'(C64);
    localparam logic signed [IW-1:0] K83  = IW'(C83);
    localparam logic signed [IW-1:0] K36  = IW'(C36);
    localparam logic signed [IW-1:0] KADD = IW'(ADD);

    logic signed [IW-1:0] e0, e1, o0, o1;
    logic signed [IW-1:0] s0, s1, s2, s3;

    always_comb begin
        e0 = IW'(x0) + IW'(x3);
        e1 = IW'(x1) + IW'(x2);
        o0 = IW'(x0) - IW'(x3);
        o1 = IW'(x1) - IW'(x2);

        s0 = K64 * e0 + K64 * e1 + KADD;
        s2 = K64 * e0 - K64 * e1 + KADD;
        s1 = K83 * o0 + K36 * o1 + KADD;
        s3 = K36 * o0 - K83 * o1 + KADD;

        // >>> on signed operands: rounds toward -inf after the offset
        y0 = DW'(s0 >>> SHIFT);
        y1 = DW'(s1 >>> SHIFT);
        y2 = DW'(s2 >>> SHIFT);
        y3 = DW'(s3 >>> SHIFT);
    end

endmodule

// File: rtl/fdct4_serial.sv
// fdct4_serial: serial-in / serial-out 4-point forward DCT.
//   clk, reset            clock; synchronous active-high reset
//   in_data/in_valid      sample stream x0..x3; in_ready high while collecting
//   out_data/out_valid    coefficient stream y0..y3; held stable while out_ready low
//   out_idx               index of coefficient on out_data
//   out_last              high with y3
// Sequence per block: 4 input beats (COLLECT), 1 cycle CALC, 4 output beats (EMIT).
module fdct4_serial
    import fdct_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int SHIFT = 1,
    parameter int ADD   = 1 << (SHIFT - 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] out_data,
    output logic [1:0]           out_idx,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t state, state_nxt;

    logic [1:0]           cnt;
    logic [1:0]           idx;
    logic signed [DW-1:0] xbuf [4];
    logic signed [DW-1:0] ybuf [4];
    logic signed [DW-1:0] bf_y [4];
    logic                 in_fire, out_fire;

    fdct4_butterfly #(
        .DW    (DW),
        .SHIFT (SHIFT),
        .ADD   (ADD)
    ) u_bfly (
        .x0 (xbuf[0]),
        .x1 (xbuf[1]),
        .x2 (xbuf[2]),
        .x3 (xbuf[3]),
        .y0 (bf_y[0]),
        .y1 (bf_y[1]),
        .y2 (bf_y[2]),
        .y3 (bf_y[3])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
            cnt   <= '0;
            idx   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                xbuf[i] <= '0;
                ybuf[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                xbuf[cnt] <= in_data;
                cnt       <= cnt + 2'd1;   // wraps to 0 after x3
            end
            if (state == CALC) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    ybuf[i] <= bf_y[i];
                end
            end
            if (out_fire) begin
                idx <= idx + 2'd1;         // wraps to 0 after y3
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && cnt == 2'd3) state_nxt = CALC;
            end
            CALC: begin
                state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready && idx == 2'd3) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        out_data = ybuf[idx];
        out_idx  = idx;
        out_last = out_valid && (idx == 2'd3);
    end

endmodule

// File: tb/tb_fdct4_serial.sv
// tb_fdct4_serial: directed self-checking bench for fdct4_serial (DW=25, SHIFT=1).
module tb_fdct4_serial;

    localparam int DW = 25;
    typedef logic signed [DW-1:0] smp_t;

    logic       clk = 1'b0;
    logic       reset;
    smp_t       in_data;
    logic       in_valid;
    logic       in_ready;
    smp_t       out_data;
    logic [1:0] out_idx;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    fdct4_serial #(
        .DW    (DW),
        .SHIFT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample and hold it until accepted (bounded); ok reports acceptance.
    task automatic send_sample(input smp_t v, output bit ok);
        in_data  = v;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            else tick();
        end
        if (ok) tick();
        in_valid = 1'b0;
    endtask

    task automatic send_block(input smp_t a, input smp_t b, input smp_t c, input smp_t d,
                              output bit ok);
        bit k0, k1, k2, k3;
        send_sample(a, k0);
        send_sample(b, k1);
        send_sample(c, k2);
        send_sample(d, k3);
        ok = k0 && k1 && k2 && k3;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 25'sd7;
        out_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
            out_idx !== 2'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b out_data=%0d out_idx=%0d out_last=%0b, want 1 0 0 0 0",
                     in_ready, out_valid, out_data, out_idx, out_last);
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
    endtask

    task automatic test_dc_latency();
        smp_t exp [4] = '{25'sd1280, 25'sd0, 25'sd0, 25'sd0};
        bit   ok, k0, k1, k2;
        out_ready = 1'b1;
        send_sample(25'sd10, k0);
        send_sample(25'sd10, k1);
        send_sample(25'sd10, k2);
        // x3 beat by hand to observe the CALC cycle that follows
        in_data  = 25'sd10;
        in_valid = 1'b1;
        n_checks++;
        if (!(k0 && k1 && k2) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dc_x3_accept: accepted=%0b in_ready=%0b, want 1 1", k0 && k1 && k2, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL dc_calc_cycle: out_valid=%0b in_ready=%0b, want 0 0", out_valid, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL dc_latency: out_valid=%0b two cycles after x3, want 1", out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                if (out_valid) ok = 1'b1;
                else tick();
            end
            n_checks++;
            if (!ok || out_data !== exp[k] || out_idx !== 2'(k) || out_last !== (k == 3) ||
                in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL dc_y%0d: valid=%0b data=%0d idx=%0d last=%0b in_ready=%0b, want data=%0d idx=%0d last=%0b in_ready=0",
                         k, ok, out_data, out_idx, out_last, in_ready, exp[k], k, k == 3);
            end
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dc_return: out_valid=%0b in_ready=%0b, want 0 1", out_valid, in_ready);
        end
    endtask

    // Impulse, negative rounding and a mixed-sign vector, back to back.
    task automatic test_vectors();
        smp_t vx [4][4] = '{
            '{25'sd1, 25'sd0,  25'sd0,   25'sd0},
            '{25'sd0, 25'sd1,  25'sd0,   25'sd0},
            '{25'sd3, -25'sd2, 25'sd5,   25'sd7},
            '{-25'sd100, 25'sd50, 25'sd0, 25'sd25}
        };
        smp_t vy [4][4] = '{
            '{25'sd32,   25'sd42,    25'sd32,    25'sd18},
            '{25'sd32,   25'sd18,    -25'sd32,   -25'sd41},
            '{25'sd416,  -25'sd292,  25'sd224,   25'sd219},
            '{-25'sd800, -25'sd4287, -25'sd4000, -25'sd4325}
        };
        bit ok;
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            send_block(vx[v][0], vx[v][1], vx[v][2], vx[v][3], ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL vec%0d_input: block not accepted, want accepted", v);
            end
            for (int k = 0; k < 4; k++) begin
                ok = 1'b0;
                for (int t = 0; t < 20 && !ok; t++) begin
                    if (out_valid) ok = 1'b1;
                    else tick();
                end
                n_checks++;
                if (!ok || out_data !== vy[v][k] || out_idx !== 2'(k) || out_last !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL vec%0d_y%0d: valid=%0b data=%0d idx=%0d last=%0b, want data=%0d idx=%0d last=%0b",
                             v, k, ok, out_data, out_idx, out_last, vy[v][k], k, k == 3);
                end
                tick();
            end
        end
    endtask

    task automatic test_backpressure();
        smp_t exp [4] = '{25'sd32, 25'sd42, 25'sd32, 25'sd18};
        bit   ok;
        out_ready = 1'b0;
        send_block(25'sd1, 25'sd0, 25'sd0, 25'sd0, ok);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (out_valid) ok = 1'b1;
            else tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_start: out_valid=%0b, want 1", out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 3; s++) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== exp[k] || out_idx !== 2'(k) ||
                    in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_stall_y%0d_c%0d: valid=%0b data=%0d idx=%0d in_ready=%0b, want 1 %0d %0d 0",
                             k, s, out_valid, out_data, out_idx, in_ready, exp[k], k);
                end
                tick();
            end
            out_ready = 1'b1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp[k] || out_idx !== 2'(k) ||
                out_last !== (k == 3)) begin
                n_fail++;
                $display("FAIL bp_beat_y%0d: valid=%0b data=%0d idx=%0d last=%0b, want 1 %0d %0d %0b",
                         k, out_valid, out_data, out_idx, out_last, exp[k], k, k == 3);
            end
            tick();
            out_ready = 1'b0;
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: out_valid=%0b in_ready=%0b, want 0 1 (each coefficient once)",
                     out_valid, in_ready);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_gaps_ignored();
        smp_t xa  [4] = '{25'sd3, -25'sd2, 25'sd5, 25'sd7};
        smp_t ya  [4] = '{25'sd416, -25'sd292, 25'sd224, 25'sd219};
        smp_t yb  [4] = '{25'sd32, 25'sd42, 25'sd32, 25'sd18};
        bit   ok;
        out_ready = 1'b1;
        // valid toggles 1-0-1-0: idle cycles must not consume samples
        for (int i = 0; i < 4; i++) begin
            send_sample(xa[i], ok);
            in_data = 25'sd999;
            tick();
        end
        // garbage held valid during EMIT must be ignored
        in_data  = 25'sd555;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                if (out_valid) ok = 1'b1;
                else tick();
            end
            n_checks++;
            if (!ok || out_data !== ya[k] || out_idx !== 2'(k) || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_y%0d: valid=%0b data=%0d idx=%0d in_ready=%0b, want data=%0d idx=%0d in_ready=0",
                         k, ok, out_data, out_idx, in_ready, ya[k], k);
            end
            if (k == 3) in_valid = 1'b0;
            tick();
        end
        send_block(25'sd1, 25'sd0, 25'sd0, 25'sd0, ok);
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                if (out_valid) ok = 1'b1;
                else tick();
            end
            n_checks++;
            if (!ok || out_data !== yb[k] || out_idx !== 2'(k)) begin
                n_fail++;
                $display("FAIL gap_next_y%0d: valid=%0b data=%0d idx=%0d, want data=%0d idx=%0d",
                         k, ok, out_data, out_idx, yb[k], k);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        smp_t exp [4] = '{25'sd1280, 25'sd0, 25'sd0, 25'sd0};
        bit   ok, k0, k1;
        out_ready = 1'b1;
        // partial block: x0, x1 accepted then reset
        send_sample(25'sd7, k0);
        send_sample(25'sd9, k1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_collect: in_ready=%0b out_valid=%0b out_idx=%0d, want 1 0 0",
                     in_ready, out_valid, out_idx);
        end
        // reset during EMIT at idx 2
        send_block(25'sd1, 25'sd0, 25'sd0, 25'sd0, ok);
        ok = 1'b0;
        for (int t = 0; t < 30 && !ok; t++) begin
            if (out_valid && out_idx == 2'd2) ok = 1'b1;
            else tick();
        end
        n_checks++;
        if (!ok || out_data !== 25'sd32) begin
            n_fail++;
            $display("FAIL rst_reach_idx2: reached=%0b data=%0d, want 1 32", ok, out_data);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 2'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_emit: in_ready=%0b out_valid=%0b out_idx=%0d out_last=%0b, want 1 0 0 0",
                     in_ready, out_valid, out_idx, out_last);
        end
        send_block(25'sd10, 25'sd10, 25'sd10, 25'sd10, ok);
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                if (out_valid) ok = 1'b1;
                else tick();
            end
            n_checks++;
            if (!ok || out_data !== exp[k] || out_idx !== 2'(k) || out_last !== (k == 3)) begin
                n_fail++;
                $display("FAIL rst_after_y%0d: valid=%0b data=%0d idx=%0d last=%0b, want data=%0d idx=%0d last=%0b",
                         k, ok, out_data, out_idx, out_last, exp[k], k, k == 3);
            end
            tick();
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_dc_latency();
        test_vectors();
        test_backpressure();
        test_gaps_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
